// File: rtl/lbist_pattern_sched.sv
// Multi-seed LBIST session scheduler: per seed RST, LOAD, (SHIFT/CAP) x patterns, FLUSH, CHECK.
// Optional macro LBIST_STOP_ON_FAIL_EN ends the session at the first signature mismatch.
module lbist_pattern_sched #(
  parameter int N_MISR       = 64,
  parameter int SEED_AW      = 4,
  parameter int N_SEEDS      = 16,
  parameter int CHAIN_LEN    = 64,
  parameter int PAT_PER_SEED = 256
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [N_MISR-1:0]  misr_sig_i,
  input  logic [N_MISR-1:0]  golden_i,
  output logic [SEED_AW-1:0] seed_addr_o,
  output logic               lfsr_ld_o,
  output logic               lfsr_en_o,
  output logic               misr_en_o,
  output logic               scan_en_o,
  output logic               lfsr_misr_rst_no,
  output logic               dut_rst_no,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [SEED_AW-1:0] fail_seed_o
);

  localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = (PAT_PER_SEED > 1) ? $clog2(PAT_PER_SEED) : 1;
  localparam logic [SW-1:0]      SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0]      PAT_LAST   = PW'(PAT_PER_SEED - 1);
  localparam logic [SEED_AW-1:0] SEED_LAST  = SEED_AW'(N_SEEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_SHIFT, S_CAP, S_FLUSH, S_CHECK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      shift_cnt_q, shift_cnt_d;
  logic [PW-1:0]      pat_cnt_q, pat_cnt_d;
  logic [SEED_AW-1:0] seed_idx_q, seed_idx_d;
  logic               fail_q, fail_d;
  logic [SEED_AW-1:0] fail_seed_q, fail_seed_d;
  logic               mismatch;

  assign mismatch = (misr_sig_i != golden_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      seed_idx_q  <= '0;
      fail_q      <= 1'b0;
      fail_seed_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      seed_idx_q  <= seed_idx_d;
      fail_q      <= fail_d;
      fail_seed_q <= fail_seed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    seed_idx_d  = seed_idx_q;
    fail_d      = fail_q;
    fail_seed_d = fail_seed_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_RST;
          seed_idx_d  = '0;
          fail_d      = 1'b0;
          fail_seed_d = '0;
        end
      end
      S_RST: state_d = S_LOAD;
      S_LOAD: begin
        state_d     = S_SHIFT;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
      end
      S_SHIFT, S_FLUSH: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d     = (state_q == S_SHIFT) ? S_CAP : S_CHECK;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      S_CAP: begin
        if (pat_cnt_q == PAT_LAST) begin
          state_d = S_FLUSH;
        end else begin
          state_d   = S_SHIFT;
          pat_cnt_d = pat_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch && !fail_q) begin
          fail_d      = 1'b1;
          fail_seed_d = seed_idx_q;
        end
`ifdef LBIST_STOP_ON_FAIL_EN
        if (mismatch || seed_idx_q == SEED_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_RST;
          seed_idx_d = seed_idx_q + 1'b1;
        end
`else
        if (seed_idx_q == SEED_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_RST;
          seed_idx_d = seed_idx_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start.
    if (abort_i) begin
      state_d     = S_IDLE;
      shift_cnt_d = '0;
      pat_cnt_d   = '0;
      seed_idx_d  = '0;
      fail_d      = 1'b0;
      fail_seed_d = '0;
    end
  end

  always_comb begin
    lfsr_ld_o        = (state_q == S_LOAD);
    scan_en_o        = (state_q == S_SHIFT) || (state_q == S_FLUSH);
    misr_en_o        = scan_en_o;
    lfsr_en_o        = scan_en_o || (state_q == S_CAP);
    lfsr_misr_rst_no = (state_q != S_RST);
    dut_rst_no       = (state_q != S_RST);
    busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o           = (state_q == S_DONE);
    pass_o           = (state_q == S_DONE) && !fail_q;
  end

  assign seed_addr_o = seed_idx_q;
  assign fail_seed_o = fail_seed_q;

endmodule

// File: tb/tb_lbist_pattern_sched.sv
// Directed bench for lbist_pattern_sched with CHAIN_LEN=4, PAT_PER_SEED=3, N_SEEDS=2 (22 cycles per seed).
module tb_lbist_pattern_sched;

  localparam int N_MISR = 8;
  localparam int SEED_AW = 4;
  localparam int VW = 9 + 2 * SEED_AW;
  // ld,en,misr,scan,rst_n,dut_rst_n,busy,done,pass,seed_addr,fail_seed at reset
  localparam logic [VW-1:0] RESET_VEC = {4'b0000, 2'b11, 3'b000, {SEED_AW{1'b0}}, {SEED_AW{1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [N_MISR-1:0] misr_sig = 8'hA5;
  logic [N_MISR-1:0] golden;
  logic [15:0] bad_mask = '0;
  logic [SEED_AW-1:0] seed_addr, fail_seed;
  logic lfsr_ld, lfsr_en, misr_en, scan_en, lm_rst_n, dut_rst_n, busy, done, pass;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign golden = misr_sig ^ (bad_mask[seed_addr] ? 8'h01 : 8'h00);

  lbist_pattern_sched #(
    .N_MISR(N_MISR), .SEED_AW(SEED_AW), .N_SEEDS(2), .CHAIN_LEN(4), .PAT_PER_SEED(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .misr_sig_i(misr_sig), .golden_i(golden), .seed_addr_o(seed_addr),
    .lfsr_ld_o(lfsr_ld), .lfsr_en_o(lfsr_en), .misr_en_o(misr_en), .scan_en_o(scan_en),
    .lfsr_misr_rst_no(lm_rst_n), .dut_rst_no(dut_rst_n), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_seed_o(fail_seed)
  );

  function automatic logic [VW-1:0] out_vec();
    return {lfsr_ld, lfsr_en, misr_en, scan_en, lm_rst_n, dut_rst_n, busy, done, pass,
            seed_addr, fail_seed};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a session and follow it cycle by cycle against the per-seed control sequence.
  task automatic run_session(input logic [15:0] mask, input bit hold, input int exp_busy,
                             input logic exp_pass, input int exp_fail);
    int cyc;
    int errs;
    int p;
    int s;
    logic exp_scan;
    logic exp_en;
    logic [SEED_AW-1:0] exp_addr;
    cyc = 0;
    errs = 0;
    bad_mask = mask;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_addr", seed_addr, 0);
    while (busy && cyc < 200) begin
      p = cyc % 22;
      s = cyc / 22;
      exp_addr = s[SEED_AW-1:0];
      exp_en = (p >= 2) && (p <= 20);
      exp_scan = exp_en && (p != 6) && (p != 11) && (p != 16);
      if (scan_en !== exp_scan || misr_en !== exp_scan || lfsr_en !== exp_en ||
          lfsr_ld !== (p == 1) || lm_rst_n !== (p != 0) || dut_rst_n !== (p != 0) ||
          seed_addr !== exp_addr || done !== 1'b0)
        errs++;
      cyc++;
      step();
    end
    start = 1'b0;
    check_eq("busy_len", cyc, exp_busy);
    check_eq("ctrl_pattern", errs, 0);
    check_eq("done", done, 1);
    check_eq("pass", pass, exp_pass);
    if (!exp_pass) check_eq("fail_seed", fail_seed, exp_fail);
    check_eq("done_ctrl_idle", {lfsr_ld, lfsr_en, misr_en, scan_en, lm_rst_n, dut_rst_n}, 6'b000011);
  endtask

  initial begin
    step();
    step();
    check_eq("reset_vec", out_vec(), RESET_VEC);
    rst_n = 1'b1;
    step();
    check_eq("idle_vec", out_vec(), RESET_VEC);

    run_session(16'h0000, 1'b0, 44, 1'b1, 0);
    run_session(16'h0002, 1'b0, 44, 1'b0, 1);
`ifdef LBIST_STOP_ON_FAIL_EN
    run_session(16'h0001, 1'b0, 22, 1'b0, 0);
    run_session(16'h0003, 1'b0, 22, 1'b0, 0);
`else
    run_session(16'h0001, 1'b0, 44, 1'b0, 0);
    run_session(16'h0003, 1'b0, 44, 1'b0, 0);
`endif
    run_session(16'h0000, 1'b1, 44, 1'b1, 0);

    // Abort in cycle 10 of seed 0.
    bad_mask = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check_eq("pre_abort_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_vec", out_vec(), RESET_VEC);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_over_start", out_vec(), RESET_VEC);
    run_session(16'h0000, 1'b0, 44, 1'b1, 0);

    // Asynchronous reset during FLUSH of seed 0 (cycles 17..20).
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    check_eq("pre_rst_flush_scan", scan_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_vec", out_vec(), RESET_VEC);
    step();
    step();
    check_eq("rst_hold_vec", out_vec(), RESET_VEC);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_vec", out_vec(), RESET_VEC);
    run_session(16'h0000, 1'b0, 44, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbist_pattern_sched.md
Name: lbist_pattern_sched

Overview:
Multi-seed LBIST session scheduler. Sequences the existing LFSR / phase-shifter / MISR path around the RISC-V core: selects each seed from the seed ROM, loads the LFSR, then alternates scan-shift and capture cycles for a fixed number of patterns per seed. After each seed it flushes the chains and compares the per-seed MISR signature against a golden value from a golden-signature ROM. Sits beside the core wrapper and drives the same LFSR/MISR/scan-enable/DUT-reset controls.

Parameters:
N_MISR, 64, MISR / signature width
SEED_AW, 4, seed and golden ROM address width
N_SEEDS, 16, seeds per session (1..2^SEED_AW)
CHAIN_LEN, 64, shift cycles per pattern (>=1)
PAT_PER_SEED, 256, capture patterns per seed (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  session start pulse; sampled only in IDLE or DONE
abort_i  in  1  synchronous abort; returns to IDLE
misr_sig_i  in  N_MISR  current MISR signature
golden_i  in  N_MISR  golden signature for seed_addr_o (combinational ROM)
seed_addr_o  out  SEED_AW  seed / golden ROM address = current seed index
lfsr_ld_o  out  1  LFSR parallel load
lfsr_en_o  out  1  LFSR advance and input-mux select (TPG on)
misr_en_o  out  1  MISR compaction enable
scan_en_o  out  1  core scan enable (1 = shift)
lfsr_misr_rst_no  out  1  active-low LFSR/MISR reset
dut_rst_no  out  1  active-low core/RAM reset
busy_o  out  1  session in progress
done_o  out  1  session finished, held until next start
pass_o  out  1  all checked seeds matched; valid while done_o=1
fail_seed_o  out  SEED_AW  index of first failing seed; valid when done_o=1 and pass_o=0

Behaviour:
- Reset values: lfsr_misr_rst_no=1, dut_rst_no=1, seed_addr_o=0, all other outputs 0, state IDLE, counters 0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: start_i=1 -> RST, seed_idx=0, fail flag cleared.
- RST (1 cycle): lfsr_misr_rst_no=0, dut_rst_no=0 -> LOAD.
- LOAD (1 cycle): lfsr_ld_o=1 -> SHIFT, shift_cnt=0, pat_cnt=0.
- SHIFT (CHAIN_LEN cycles): scan_en_o=1, lfsr_en_o=1, misr_en_o=1. Transition to CAP when shift_cnt=CHAIN_LEN-1.
- CAP (1 cycle): scan_en_o=0, lfsr_en_o=1, misr_en_o=0.
  - If pat_cnt=PAT_PER_SEED-1 -> FLUSH.
  - Otherwise pat_cnt++ -> SHIFT.
- FLUSH (CHAIN_LEN cycles): same outputs as SHIFT; unloads the last response -> CHECK.
- CHECK (1 cycle): lfsr_en_o=0, misr_en_o=0. Compare misr_sig_i with golden_i.
  - On mismatch with no prior failure: latch fail_seed_o=seed_idx.
  - If seed_idx=N_SEEDS-1 -> DONE; else seed_idx++ -> RST.
- DONE: done_o=1, busy_o=0, pass_o = no mismatch recorded. start_i -> RST with done_o cleared and the fail record cleared.
- busy_o=1 in every state except IDLE and DONE. lfsr_ld_o, lfsr_en_o and misr_en_o are mutually consistent: ld and en are never both 1.
- Cycles per seed = 3 + PAT_PER_SEED*(CHAIN_LEN+1) + CHAIN_LEN. Session busy time = N_SEEDS times that.
- start_i while busy: ignored.
- abort_i: from any state -> IDLE next cycle with reset-value outputs. abort_i has priority over start_i in the same cycle.
- Counter widths are $clog2-sized with no wrap inside a seed. seed_idx does not wrap; the session ends at N_SEEDS-1.
- Asynchronous reset mid-session: immediate return to reset values and IDLE.

Optional Feature:
- LBIST_STOP_ON_FAIL_EN defined: the first CHECK mismatch goes directly to DONE with pass_o=0 and fail_seed_o=that seed; remaining seeds are skipped.
- Undefined: all N_SEEDS are always run; fail_seed_o holds the first failing index and later mismatches do not overwrite it.

Test Plan:
- CHAIN_LEN=4, PAT_PER_SEED=3, N_SEEDS=2, golden always equal to misr_sig_i; start pulse -> busy_o high exactly 44 cycles, then done_o=1, pass_o=1. Scan_en_o pattern per seed is 4 high / 1 low repeated 3 times, then 4 high.
- Same config, golden mismatch on seed 1 only -> done_o=1, pass_o=0, fail_seed_o=1. With LBIST_STOP_ON_FAIL_EN, mismatch on seed 0 -> done_o after 22 busy cycles, fail_seed_o=0.
- Check per-seed control pulses: exactly one lfsr_misr_rst_no=0 cycle, then one lfsr_ld_o=1 cycle with seed_addr_o=seed index, and lfsr_en_o=0 during both.
- abort_i asserted in cycle 10 of seed 0 -> next cycle IDLE, all outputs at reset values, done_o=0. A subsequent start_i runs a full 44-cycle session.
- start_i held high during the busy period -> no restart, with total busy length still 44. start_i in DONE -> done_o drops and a new session begins with seed_addr_o=0.
- rst_ni pulled low during FLUSH -> outputs return to reset values asynchronously, with no done_o pulse.
